// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the output-stationary systolic matrix-multiply engine.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } mm_state_e;

    // Floor for counter widths so a degenerate 1-entry dimension still gets a real bit.
    localparam int MIN_CNT_W = 1;

    function automatic int acc_width(input int dw, input int kmax);
        return 2 * dw + $clog2(kmax);
    endfunction

    function automatic int klen_width(input int kmax);
        return $clog2(kmax + 1);
    endfunction

    function automatic int flush_width(input int rows, input int cols);
        return ($clog2(rows + cols) > MIN_CNT_W) ? $clog2(rows + cols) : MIN_CNT_W;
    endfunction

    function automatic int row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : MIN_CNT_W;
    endfunction

endpackage

// File: rtl/systolic_mac_pe.sv
// One multiply-accumulate cell: forwards a right and b down every cycle, accumulates when enabled.
module systolic_mac_pe #(
    parameter int DW   = 16,
    parameter int ACCW = 38
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [DW-1:0]   a_in,
    input  logic signed [DW-1:0]   b_in,
    output logic signed [DW-1:0]   a_out,
    output logic signed [DW-1:0]   b_out,
    output logic signed [ACCW-1:0] acc
);

    logic signed [2*DW-1:0] prod;

    assign prod = (2*DW)'(a_in) * (2*DW)'(b_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            if (en) begin
                acc <= acc + ACCW'(prod);
            end
        end
    end

endmodule

// File: rtl/systolic_mm_engine.sv
// ROWS x COLS output-stationary signed matrix-multiply engine with streaming operand input,
// internal skew, and a row-by-row result drain. Handshake: a beat/row moves when valid && ready.
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int KMAX      = 64
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic [klen_width(KMAX)-1:0]              k_len,
    output logic                                     busy,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [ROWS*DATAWIDTH-1:0]                a_col,
    input  logic [COLS*DATAWIDTH-1:0]                b_row,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [COLS*acc_width(DATAWIDTH,KMAX)-1:0] out_data,
    output logic [row_width(ROWS)-1:0]               out_row,
    output logic                                     out_last,
    output logic                                     done
);

    localparam int DW   = DATAWIDTH;
    localparam int ACCW = acc_width(DATAWIDTH, KMAX);
    localparam int KW   = klen_width(KMAX);
    localparam int FW   = flush_width(ROWS, COLS);
    localparam int RW   = row_width(ROWS);

    mm_state_e state, state_nxt;
    logic [KW-1:0] k_reg, beat_cnt, k_clamped;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] row_cnt;
    logic          accept, last_beat, row_hs, last_row, clr, en;

    assign k_clamped = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (beat_cnt == k_reg - KW'(1));
    assign last_row  = (row_cnt == RW'(ROWS - 1));
    assign row_hs    = out_valid && out_ready;
    assign clr       = (state == IDLE) && start;
    assign en        = (state == LOAD) || (state == FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (k_clamped != '0) ? LOAD : DRAIN;
            LOAD:    if (last_beat) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == '0) state_nxt = DRAIN;
            DRAIN:   if (row_hs && last_row) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        in_ready  = (state == LOAD);
        out_valid = (state == DRAIN);
        out_last  = (state == DRAIN) && last_row;
    end

    // Flush counter covers the skew plus array traversal so the far corner PE sees its last product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            done <= row_hs && last_row;
            if (clr) begin
                k_reg     <= k_clamped;
                beat_cnt  <= '0;
                flush_cnt <= '0;
                row_cnt   <= '0;
            end
            if (accept) beat_cnt <= beat_cnt + KW'(1);
            if (last_beat) flush_cnt <= FW'(ROWS + COLS - 2);
            else if ((state == FLUSH) && (flush_cnt != '0)) flush_cnt <= flush_cnt - FW'(1);
            if (row_hs) row_cnt <= last_row ? '0 : row_cnt + RW'(1);
        end
    end

    logic signed [DW-1:0]   a_edge [ROWS];
    logic signed [DW-1:0]   b_edge [COLS];
    logic signed [DW-1:0]   a_skew [ROWS];
    logic signed [DW-1:0]   b_skew [COLS];
    logic signed [DW-1:0]   a_fwd  [ROWS][COLS];
    logic signed [DW-1:0]   b_fwd  [ROWS][COLS];
    logic signed [ACCW-1:0] acc_arr[ROWS][COLS];

    // Cycles without an accepted beat push zeros, so bubbles add nothing to the sums.
    always_comb begin
        for (int r = 0; r < ROWS; r++) a_edge[r] = accept ? a_col[r*DW +: DW] : '0;
        for (int c = 0; c < COLS; c++) b_edge[c] = accept ? b_row[c*DW +: DW] : '0;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_pass
            assign a_skew[r] = a_edge[r];
        end else begin : g_dly
            logic signed [DW-1:0] dly [r];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) dly[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < r; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= a_edge[r];
                    for (int i = 1; i < r; i++) dly[i] <= dly[i-1];
                end
            end
            assign a_skew[r] = dly[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_pass
            assign b_skew[c] = b_edge[c];
        end else begin : g_dly
            logic signed [DW-1:0] dly [c];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c; i++) dly[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < c; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= b_edge[c];
                    for (int i = 1; i < c; i++) dly[i] <= dly[i-1];
                end
            end
            assign b_skew[c] = dly[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [DW-1:0] a_in_w, b_in_w;
            if (c == 0) begin : g_a_edge
                assign a_in_w = a_skew[r];
            end else begin : g_a_mid
                assign a_in_w = a_fwd[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign b_in_w = b_skew[c];
            end else begin : g_b_mid
                assign b_in_w = b_fwd[r-1][c];
            end
            systolic_mac_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .en    (en),
                .a_in  (a_in_w),
                .b_in  (b_in_w),
                .a_out (a_fwd[r][c]),
                .b_out (b_fwd[r][c]),
                .acc   (acc_arr[r][c])
            );
        end
    end

    // Operands leaving the far edges of the array have no consumer.
    logic unused_edge;
    always_comb begin
        unused_edge = 1'b0;
        for (int r = 0; r < ROWS; r++) unused_edge = unused_edge ^ (^a_fwd[r][COLS-1]);
        for (int c = 0; c < COLS; c++) unused_edge = unused_edge ^ (^b_fwd[ROWS-1][c]);
    end

    assign out_row = row_cnt;

    always_comb begin
        out_data = '0;
        if (state == DRAIN) begin
            for (int c = 0; c < COLS; c++) out_data[c*ACCW +: ACCW] = acc_arr[row_cnt][c];
        end
    end

endmodule
